// File: rtl/pipelined_barrel_shifter_if.sv
// Stream bundle for pipelined_barrel_shifter: input word/handshake, output word/handshake, busy.
// Latency: none, signal bundle only.
// Backpressure: in_ready/out_ready carry valid-ready flow control on each side.
// Ports (slave = shifter side):
//   in_valid/in_ready/num/shift/mode  - upstream word and shift command
//   out_valid/out_ready/result        - downstream shifted word
//   busy                              - any pipeline stage occupied
interface pipelined_barrel_shifter_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num;
  logic [N-1:0] shift;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  modport slave (
    input  in_valid, num, shift, mode, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, num, shift, mode, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (rotate right/left, logical left, arithmetic right), W = 2**N.
// Latency: N edges from acceptance to result, one word per cycle sustained.
// Backpressure: per-stage advance; bubbles collapse, in_ready drops only when all N stages are full.
// Ports:
//   clk, reset_n - rising-edge clock, asynchronous active-low reset
//   bus (slave)  - in_valid/in_ready/num/shift/mode in, out_valid/out_ready/result out, busy
module pipelined_barrel_shifter #(
  parameter int N = 3
) (
  input logic                        clk,
  input logic                        reset_n,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int W = 1 << N;

  // Stage k registers
  logic [N-1:0]          valid_q;
  logic [N-1:0][W-1:0]   data_q;
  logic [N-1:0][N-1:0]   shift_q;
  logic [N-1:0][1:0]     mode_q;

  // Operand presented to stage k (stage 0 reads the bus directly)
  logic [N-1:0]          src_valid;
  logic [N-1:0][W-1:0]   src_data;
  logic [N-1:0][N-1:0]   src_shift;
  logic [N-1:0][1:0]     src_mode;
  logic [N-1:0][W-1:0]   nxt_data;

  logic [N-1:0]          adv;

  // One fixed-distance shift step. Arithmetic right fills from the current
  // MSB; every earlier step in that mode preserved it, so this is the
  // original word's sign bit.
  function automatic logic [W-1:0] shift_by(input logic [W-1:0] d,
                                            input logic [1:0]   m,
                                            input int           amt);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = (d >> amt) | (d << (W - amt));
      2'b01:   r = (d << amt) | (d >> (W - amt));
      2'b10:   r = d << amt;
      default: r = $signed(d) >>> amt;
    endcase
    return r;
  endfunction

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.num;
    src_shift[0] = bus.shift;
    src_mode[0]  = bus.mode;
    for (int k = 1; k < N; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shift[k] = shift_q[k-1];
      src_mode[k]  = mode_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      nxt_data[k] = src_shift[k][k] ? shift_by(src_data[k], src_mode[k], 1 << k)
                                    : src_data[k];
    end
  end

  // Stage k may load unless it and every stage after it are full while the
  // sink stalls. Written in closed form so no bit of adv depends on another.
  for (genvar k = 0; k < N; k++) begin : g_adv
    assign adv[k] = bus.out_ready | ~(&valid_q[N-1:k]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
      shift_q <= '0;
      mode_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (adv[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= nxt_data[k];
          shift_q[k] <= src_shift[k];
          mode_q[k]  <= src_mode[k];
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[N-1];
  assign bus.result    = data_q[N-1];
  assign bus.busy      = |valid_q;

  // The last stage's command fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shift_q[N-1], mode_q[N-1]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed vectors, streaming, backpressure and reset at N=3,
// plus randomized streams with random out_ready at N=4 and N=1 against a bit-level model.
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0;
  logic rst_n;
  bit   rnd_go = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.N(3)) bif ();
  pipelined_barrel_shifter #(.N(3)) u_dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-level reference: output bit i is picked from the input by position.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int s,
                                            input logic [1:0] m, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = x[(i + s) % w];
        2'b01:   r[i] = x[(i - s + w) % w];
        2'b10:   r[i] = (i >= s) ? x[i - s] : 1'b0;
        default: r[i] = (i + s < w) ? x[i + s] : x[w - 1];
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] ref8(input logic [7:0] x, input logic [2:0] s, input logic [1:0] m);
    logic [15:0] r;
    r = ref_shift(16'(x), int'(s), m, 8);
    return r[7:0];
  endfunction

  // One word into an empty pipeline; out_valid must rise exactly 3 edges after acceptance.
  task automatic run_one(input string tag, input logic [7:0] n, input logic [2:0] s,
                         input logic [1:0] m, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, ".irdy"}, 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.num      = n;
    bif.shift    = s;
    bif.mode     = m;
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      chk({tag, ".vld"}, 32'(bif.out_valid), 32'(c == 3));
    end
    chk({tag, ".res"}, 32'(bif.result), 32'(exp));
  endtask

  logic [7:0] q[$];
  logic [7:0] bp_num[5];
  logic [2:0] bp_sh[5];
  logic [1:0] bp_md[5];
  int         idx;
  int         got;

  task automatic drive_bp(input int i);
    if (i < 5) begin
      bif.in_valid = 1'b1;
      bif.num      = bp_num[i];
      bif.shift    = bp_sh[i];
      bif.mode     = bp_md[i];
    end else begin
      bif.in_valid = 1'b0;
    end
  endtask

  task automatic sample_bp();
    if (bif.out_valid && bif.out_ready) begin
      if (q.size() == 0) chk("bp_extra", 32'd1, 32'd0);
      else begin
        chk("bp_res", 32'(bif.result), 32'(q.pop_front()));
        got++;
      end
    end
    if (bif.in_valid && bif.in_ready) begin
      q.push_back(ref8(bif.num, bif.shift, bif.mode));
      idx++;
    end
  endtask

  int d_md[9]  = '{0, 1, 2, 3, 1, 0, 1, 2, 3};
  int d_sh[9]  = '{1, 1, 3, 2, 7, 0, 0, 0, 0};
  int d_exp[9] = '{'h69, 'hA5, 'h90, 'hF4, 'h69, 'hD2, 'hD2, 'hD2, 'hD2};

  initial begin
    logic [7:0] st_num[8];

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    bif.num       = '0;
    bif.shift     = '0;
    bif.mode      = '0;

    #12;
    chk("rst_ovld", 32'(bif.out_valid), 32'd0);
    chk("rst_res",  32'(bif.result),    32'd0);
    chk("rst_busy", 32'(bif.busy),      32'd0);
    chk("rst_irdy", 32'(bif.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on 8'b1101_0010
    for (int i = 0; i < 9; i++)
      run_one($sformatf("dir%0d", i), 8'hD2, 3'(d_sh[i]), 2'(d_md[i]), 8'(d_exp[i]));

    // Back-to-back stream, all shift amounts, rotate right
    for (int i = 0; i < 8; i++) st_num[i] = 8'($urandom);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk("st_vld", 32'(bif.out_valid), 32'd1);
        chk("st_res", 32'(bif.result), 32'(ref8(st_num[c-3], 3'(c-3), 2'b00)));
      end else begin
        chk("st_vld", 32'(bif.out_valid), 32'd0);
      end
      if (c < 8) begin
        chk("st_irdy", 32'(bif.in_ready), 32'd1);
        bif.in_valid = 1'b1;
        bif.num      = st_num[c];
        bif.shift    = 3'(c);
        bif.mode     = 2'b00;
      end else begin
        bif.in_valid = 1'b0;
      end
    end

    // Backpressure: sink stalled, five words offered
    for (int i = 0; i < 5; i++) begin
      bp_num[i] = 8'($urandom);
      bp_sh[i]  = 3'($urandom);
      bp_md[i]  = 2'($urandom);
    end
    idx = 0;
    got = 0;
    q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bif.out_ready = 1'b0;
      drive_bp(idx);
      #1 sample_bp();
    end
    @(negedge clk);
    chk("bp_acc",  32'(idx),           32'd3);
    chk("bp_irdy", 32'(bif.in_ready),  32'd0);
    chk("bp_busy", 32'(bif.busy),      32'd1);
    chk("bp_ovld", 32'(bif.out_valid), 32'd1);
    bif.out_ready = 1'b1;
    #1 chk("bp_irdy_rise", 32'(bif.in_ready), 32'd1);
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (c > 0) begin
        @(negedge clk);
        drive_bp(idx);
        #1;
      end
      sample_bp();
    end
    chk("bp_got",  32'(got),      32'd5);
    chk("bp_left", 32'(q.size()), 32'd0);
    @(negedge clk);
    bif.in_valid = 1'b0;

    // Reset with words in flight
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.num      = 8'hFF;
    bif.shift    = 3'd1;
    bif.mode     = 2'b11;
    @(negedge clk);
    bif.num      = 8'h3C;
    bif.mode     = 2'b00;
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_ovld", 32'(bif.out_valid), 32'd1);
    chk("pre_res",  32'(bif.result),    32'hFF);
    chk("pre_busy", 32'(bif.busy),      32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ovld", 32'(bif.out_valid), 32'd0);
    chk("mid_busy", 32'(bif.busy),      32'd0);
    chk("mid_res",  32'(bif.result),    32'd0);
    chk("mid_irdy", 32'(bif.in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("post_rst", 8'hD2, 3'd1, 2'b01, 8'hA5);

    // Randomized runs on the other widths
    rnd_go = 1'b1;
    for (int c = 0; c < 6000 && !(g_rnd[0].fin && g_rnd[1].fin); c++) @(posedge clk);
    chk("rnd_done", 32'(g_rnd[0].fin && g_rnd[1].fin), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int NN = (g == 0) ? 4 : 1;
    localparam int WW = 1 << NN;
    localparam int NW = 80;

    bit fin = 1'b0;

    pipelined_barrel_shifter_if #(.N(NN)) rif ();
    pipelined_barrel_shifter #(.N(NN)) u_rnd (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (rif.slave)
    );

    initial begin
      logic [15:0] mq[$];
      int          sent;
      int          rcv;
      bit          pend;

      rif.in_valid  = 1'b0;
      rif.out_ready = 1'b1;
      rif.num       = '0;
      rif.shift     = '0;
      rif.mode      = '0;
      sent = 0;
      rcv  = 0;
      pend = 1'b0;
      wait (rnd_go);
      for (int cyc = 0; cyc < 3000 && rcv < NW; cyc++) begin
        @(negedge clk);
        rif.out_ready = ($urandom_range(0, 3) != 0);
        if (!pend && sent < NW && $urandom_range(0, 3) != 0) begin
          rif.num   = WW'($urandom);
          rif.shift = NN'($urandom_range(0, WW - 1));
          rif.mode  = 2'($urandom);
          pend      = 1'b1;
        end
        rif.in_valid = pend;
        #1;
        chk($sformatf("rnd%0d_busy", NN), 32'(rif.busy), 32'(mq.size() != 0));
        chk($sformatf("rnd%0d_irdy", NN), 32'(rif.in_ready),
            32'((mq.size() < NN) || rif.out_ready));
        if (rif.out_valid && rif.out_ready) begin
          if (mq.size() == 0) chk($sformatf("rnd%0d_extra", NN), 32'd1, 32'd0);
          else begin
            chk($sformatf("rnd%0d_res", NN), 32'(rif.result), 32'(mq.pop_front()));
            rcv++;
          end
        end
        if (rif.in_valid && rif.in_ready) begin
          mq.push_back(ref_shift(16'(rif.num), int'(rif.shift), rif.mode, WW));
          sent++;
          pend = 1'b0;
        end
      end
      @(negedge clk);
      rif.in_valid = 1'b0;
      chk($sformatf("rnd%0d_cnt", NN), 32'(rcv), 32'(NW));
      fin = 1'b1;
    end
  end
endmodule
